// File: rtl/alu_div_seq.sv
// -----------------------------------------------------------------------------
// alu_div_seq
//
// Multicycle signed integer divider for the ALU/multdiv datapath. It uses a
// restoring shift-subtract algorithm on operand magnitudes and produces one
// quotient bit per clock. The signs are applied when the result is written
// out: the quotient truncates toward zero and the remainder takes the sign
// of the dividend.
//
// Timing, with the start edge called E0:
//   E0            ctrl_DIV sampled high; operands latched; busy rises
//   E1..E_WIDTH   one quotient bit per edge
//   E_WIDTH+1     result registered; data_resultRDY high for one cycle
// The latency is fixed at WIDTH+1 edges for every operand pair, including
// divide-by-zero.
//
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous, active-high reset
//   data_operandA   dividend (signed), sampled on the start edge only
//   data_operandB   divisor (signed), sampled on the start edge only
//   ctrl_DIV        start pulse; a pulse while busy aborts and restarts
//   data_result     quotient (signed), held until the next completion
//   data_remainder  remainder (signed), held until the next completion
//   data_exception  divide-by-zero flag, valid with data_resultRDY
//   data_resultRDY  one-cycle completion pulse
//   busy            high while a division is in progress
// -----------------------------------------------------------------------------
module alu_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement negation, modulo 2^WIDTH. The bit pattern of
  // -2^(WIDTH-1) maps to itself, which gives the correct unsigned magnitude
  // and the wrapping overflow quotient.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  state_t           state;
  state_t           state_next;

  // Decoded controls produced by the FSM output process.
  logic             load;     // latch operands and start a new division
  logic             step;     // perform one shift-subtract iteration
  logic             finish;   // write results and pulse data_resultRDY

  // Datapath registers.
  logic [WIDTH-1:0] quo;      // dividend magnitude shifted out, quotient in
  logic [WIDTH-1:0] rem;      // partial remainder, always below b_abs
  logic [WIDTH-1:0] b_abs;    // divisor magnitude
  logic             sign_q;
  logic             sign_r;
  logic             divzero;
  logic [CNT_W-1:0] cnt;

  // Combinational iteration and operand-conditioning signals.
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs_in;
  logic [WIDTH:0]   rem_shift;  // WIDTH+1 bits: shifted remainder for the trial
  logic [WIDTH-1:0] trial;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             last_iter;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments, so every register
  // samples values from before the edge regardless of process order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // A start pulse wins in every state. It starts from IDLE and aborts and
  // restarts from RUN or DONE, so an aborted operation never reaches DONE.
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first means no path leaves state_next
  // unassigned, so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (ctrl_DIV) state_next = RUN;
      RUN: begin
        if (ctrl_DIV)       state_next = RUN;
        else if (last_iter) state_next = DONE;
      end
      DONE: state_next = ctrl_DIV ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    busy   = (state != IDLE);
    load   = ctrl_DIV;
    step   = (state == RUN)  && !ctrl_DIV;
    finish = (state == DONE) && !ctrl_DIV;
  end

  // ---------------------------------------------------------------------------
  // Operand conditioning and one restoring iteration
  // ---------------------------------------------------------------------------
  always_comb begin
    a_abs    = data_operandA[WIDTH-1] ? negate(data_operandA) : data_operandA;
    b_abs_in = data_operandB[WIDTH-1] ? negate(data_operandB) : data_operandB;

    // Shift {rem,quo} left by one. The dividend bit moving out of quo
    // enters the remainder.
    rem_shift = {rem, quo[WIDTH-1]};
    no_borrow = (rem_shift >= {1'b0, b_abs});
    // When there is no borrow, the difference is below b_abs and fits in
    // WIDTH bits, so a WIDTH-bit subtraction is exact.
    trial     = rem_shift[WIDTH-1:0] - b_abs;
    rem_next  = no_borrow ? trial : rem_shift[WIDTH-1:0];
    quo_next  = {quo[WIDTH-2:0], no_borrow};

    last_iter = (cnt == CNT_W'(WIDTH - 1));
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quo     <= '0;
      rem     <= '0;
      b_abs   <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      divzero <= 1'b0;
      cnt     <= '0;
    end else if (load) begin
      quo     <= a_abs;
      rem     <= '0;
      b_abs   <= b_abs_in;
      sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      sign_r  <= data_operandA[WIDTH-1];
      divzero <= (data_operandB == '0);
      cnt     <= '0;
    end else if (step) begin
      quo     <= quo_next;
      rem     <= rem_next;
      cnt     <= cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers: written once per completed division and held until
  // the next completion. A divisor of zero forces both results to zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= finish;
      if (finish) begin
        data_exception <= divzero;
        if (divzero) begin
          data_result    <= '0;
          data_remainder <= '0;
        end else begin
          data_result    <= sign_q ? negate(quo) : quo;
          data_remainder <= sign_r ? negate(rem) : rem;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_div_seq
//
// Directed-vector bench for alu_div_seq (WIDTH = 32). Inputs are driven on
// the falling edge, and outputs are sampled 1 ns after the rising edge.
// Expected values for the directed vectors are hand-computed. The random
// vectors use a small truncating-division reference.
// -----------------------------------------------------------------------------
module tb_alu_div_seq;

  localparam int WIDTH   = 32;
  localparam int LATENCY = WIDTH + 1;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic [WIDTH-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  int n_vec;
  int n_miss;

  // Results of the last completed division, which the outputs must hold.
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_r;
  logic             prev_e;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             e;
  } vec_t;

  vec_t vecs[10] = '{
    '{32'd100,         32'd7,           32'd14,          32'd2,           1'b0},
    '{-32'sd100,       32'd7,           -32'sd14,        -32'sd2,         1'b0},
    '{32'd100,         -32'sd7,         -32'sd14,        32'd2,           1'b0},
    '{-32'sd100,       -32'sd7,         32'd14,          -32'sd2,         1'b0},
    '{32'd0,           32'd5,           32'd0,           32'd0,           1'b0},
    '{32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   32'd0,           1'b0},
    '{32'h8000_0000,   32'd1,           32'h8000_0000,   32'd0,           1'b0},
    '{32'd7,           32'd0,           32'd0,           32'd0,           1'b1},
    '{32'h8000_0000,   32'h8000_0000,   32'd1,           32'd0,           1'b0},
    '{32'd1_000_000,   32'd1,           32'd1_000_000,   32'd0,           1'b0}
  };

  alu_div_seq #(.WIDTH(WIDTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference for the random vectors: truncating division; the remainder
  // takes the dividend's sign.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                output logic e);
    if (b == '0) begin
      q = '0; r = '0; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0; e = 1'b0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      e = 1'b0;
    end
  endfunction

  // Pulse ctrl_DIV for one rising edge (E0). Afterwards, scramble the
  // operands to show that they are sampled only on the start edge.
  task automatic start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Count rising edges after E0 until data_resultRDY is seen. Midway, check
  // that busy is high and the previous results are still held. Returns 0
  // if no RDY arrives within the budget.
  task automatic wait_rdy(output int n);
    n = 0;
    for (int i = 1; i <= 3 * LATENCY; i++) begin
      @(posedge clock);
      #1;
      if (i == 16) begin
        check("busy_mid", busy, 1);
        check("hold_q_mid", data_result, prev_q);
        check("hold_r_mid", data_remainder, prev_r);
        check("hold_e_mid", data_exception, prev_e);
      end
      if (data_resultRDY) begin
        n = i;
        break;
      end
    end
  endtask

  // Run one division and check its latency, results, and the one-cycle RDY
  // pulse. With chain set, return in the RDY cycle so that the next start
  // lands while RDY is high.
  task automatic run_div(input string tag,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                         input logic ee, input bit chain);
    int n;
    start(a, b);
    check({tag, "_busy_start"}, busy, 1);
    wait_rdy(n);
    check({tag, "_latency"}, n, LATENCY);
    check({tag, "_q"}, data_result, eq);
    check({tag, "_r"}, data_remainder, er);
    check({tag, "_exc"}, data_exception, ee);
    check({tag, "_busy_done"}, busy, 0);
    prev_q = eq;
    prev_r = er;
    prev_e = ee;
    if (!chain) begin
      @(posedge clock);
      #1;
      check({tag, "_rdy_1cyc"}, data_resultRDY, 0);
      check({tag, "_hold_q"}, data_result, eq);
      check({tag, "_hold_r"}, data_remainder, er);
    end
  endtask

  initial begin
    bit seen;
    logic [WIDTH-1:0] ra, rb, rq, rr;
    logic             re;

    n_vec         = 0;
    n_miss        = 0;
    prev_q        = '0;
    prev_r        = '0;
    prev_e        = 1'b0;
    reset         = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;

    // Reset state.
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_q", data_result, 0);
    check("rst_r", data_remainder, 0);
    check("rst_exc", data_exception, 0);
    check("rst_rdy", data_resultRDY, 0);
    check("rst_busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;

    // Directed vectors: basic division, sign combinations, overflow, and
    // divide-by-zero.
    foreach (vecs[i])
      run_div($sformatf("dir%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].e, 1'b0);

    // Restart: a second start 10 edges after the first. Only the second
    // operation completes.
    start(32'd100, 32'd7);
    seen = 1'b0;
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen = 1'b1;
    end
    check("restart_no_early_rdy", seen, 0);
    run_div("restart", 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0);

    // Reset in the middle of an operation.
    start(32'd1000, 32'd3);
    repeat (15) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_q", data_result, 0);
    check("midrst_r", data_remainder, 0);
    check("midrst_exc", data_exception, 0);
    check("midrst_rdy", data_resultRDY, 0);
    check("midrst_busy", busy, 0);
    @(negedge clock);
    reset  = 1'b0;
    prev_q = '0;
    prev_r = '0;
    prev_e = 1'b0;
    seen   = 1'b0;
    repeat (LATENCY + 5) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen = 1'b1;
    end
    check("midrst_no_rdy", seen, 0);
    run_div("after_rst", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b0);

    // Start in the same cycle that RDY is high.
    run_div("chain_a", 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    run_div("chain_b", 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 1'b0, 1'b0);

    // Random signed pairs against the reference.
    for (int i = 0; i < 200; i++) begin
      ra = (i % 3 == 0) ? WIDTH'($urandom_range(0, 2000)) - WIDTH'(1000) : WIDTH'($urandom);
      rb = (i % 4 == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 200)) - WIDTH'(100);
      model(ra, rb, rq, rr, re);
      run_div($sformatf("rnd%0d", i), ra, rb, rq, rr, re, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
